tl_intersection_model: RTL and testbench

//  Drives the traffic-light controller's sensor inputs from its light outputs.

---
 rtl/tl_intersection_model_pkg.sv | 22 ++
 rtl/tl_intersection_model_lane_queue.sv | 61 ++++++
 rtl/tl_intersection_model.sv | 51 +++++
 tb/tb_tl_intersection_model.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tl_intersection_model_pkg.sv
// Shared definitions for the intersection model: light codes as seen on La/Lb.
// The controller uses the same encoding.
package tl_intersection_model_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        LEFT   = 2'b11
    } light_e;

    localparam int unsigned LANES = 4;

    function automatic logic straight_permit(input logic [1:0] light);
        return light == GREEN;
    endfunction

    function automatic logic left_permit(input logic [1:0] light);
        return light == LEFT;
    endfunction

endpackage

// File: rtl/tl_intersection_model_lane_queue.sv
// One vehicle queue: counts arrivals in, paces departures out every DEP_INT
// cycles while permitted, saturates with a sticky overflow flag.
module lane_queue #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DEP_INT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             permit,
    input  logic             arr,
    output logic [CNT_W-1:0] q,
    output logic             occ,
    output logic             dep,
    output logic             ovf
);

    localparam int unsigned      TW    = (DEP_INT > 1) ? $clog2(DEP_INT) : 1;
    localparam logic [TW-1:0]    TLAST = TW'(DEP_INT - 1);
    localparam logic [CNT_W-1:0] QMAX  = '1;

    logic [CNT_W-1:0] q_q, q_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             dep_q, dep_d;
    logic             ovf_q, ovf_d;
    logic             active;

    always_comb begin
        active  = permit && (q_q != '0);
        dep_d   = active && (timer_q == TLAST);
        timer_d = (!active || dep_d) ? '0 : timer_q + TW'(1);
        q_d     = q_q;
        ovf_d   = ovf_q;
        // Arrival and departure on the same edge cancel out.
        if (arr && !dep_d) begin
            if (q_q == QMAX) ovf_d = 1'b1;
            else             q_d   = q_q + CNT_W'(1);
        end else if (!arr && dep_d) begin
            q_d = q_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q     <= '0;
            timer_q <= '0;
            dep_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            timer_q <= timer_d;
            dep_q   <= dep_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q   = q_q;
    assign occ = (q_q != '0);
    assign dep = dep_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/tl_intersection_model.sv
// Closed-loop intersection model: decodes light codes into lane permits and
// feeds four independent lane queues whose occupancy drives the sensor outputs.
module tl_intersection_model
    import tl_intersection_model_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DEP_INT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic [3:0]       arr,
    output logic             Ta,
    output logic             Tal,
    output logic             Tb,
    output logic             Tbl,
    output logic [CNT_W-1:0] qa,
    output logic [CNT_W-1:0] qal,
    output logic [CNT_W-1:0] qb,
    output logic [CNT_W-1:0] qbl,
    output logic [3:0]       dep,
    output logic [3:0]       ovf
);

    logic [LANES-1:0] permit;

    assign permit = {left_permit(Lb), straight_permit(Lb),
                     left_permit(La), straight_permit(La)};

    lane_queue #(.CNT_W(CNT_W), .DEP_INT(DEP_INT)) u_a (
        .clk(clk), .reset_n(reset_n), .permit(permit[0]), .arr(arr[0]),
        .q(qa), .occ(Ta), .dep(dep[0]), .ovf(ovf[0])
    );

    lane_queue #(.CNT_W(CNT_W), .DEP_INT(DEP_INT)) u_al (
        .clk(clk), .reset_n(reset_n), .permit(permit[1]), .arr(arr[1]),
        .q(qal), .occ(Tal), .dep(dep[1]), .ovf(ovf[1])
    );

    lane_queue #(.CNT_W(CNT_W), .DEP_INT(DEP_INT)) u_b (
        .clk(clk), .reset_n(reset_n), .permit(permit[2]), .arr(arr[2]),
        .q(qb), .occ(Tb), .dep(dep[2]), .ovf(ovf[2])
    );

    lane_queue #(.CNT_W(CNT_W), .DEP_INT(DEP_INT)) u_bl (
        .clk(clk), .reset_n(reset_n), .permit(permit[3]), .arr(arr[3]),
        .q(qbl), .occ(Tbl), .dep(dep[3]), .ovf(ovf[3])
    );

endmodule

// File: tb/tb_tl_intersection_model.sv
// Directed bench for tl_intersection_model with CNT_W=4, DEP_INT=2.
module tb_tl_intersection_model;

    localparam logic [1:0] C_GREEN = 2'b00;
    localparam logic [1:0] C_RED   = 2'b10;
    localparam logic [1:0] C_LEFT  = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] La, Lb;
    logic [3:0] arr;
    logic       Ta, Tal, Tb, Tbl;
    logic [3:0] qa, qal, qb, qbl;
    logic [3:0] dep, ovf;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    tl_intersection_model #(.CNT_W(4), .DEP_INT(2)) dut (
        .clk(clk), .reset_n(reset_n), .La(La), .Lb(Lb), .arr(arr),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .qa(qa), .qal(qal), .qb(qb), .qbl(qbl),
        .dep(dep), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before tick are sampled on its edge; outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned exp_qa  [6] = '{3, 2, 2, 1, 1, 0};
        logic        exp_dep [6] = '{0, 1, 0, 1, 0, 1};

        reset_n = 1'b0; La = C_RED; Lb = C_RED; arr = '0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_q",   {qa, qal, qb, qbl}, 32'h0);
        check("rst_T",   {Ta, Tal, Tb, Tbl}, 32'h0);
        check("rst_dep", dep, 32'h0);
        check("rst_ovf", ovf, 32'h0);

        // Arrivals on lane a under RED
        arr = 4'b0001;
        tick();
        check("a_q1", qa, 32'd1);
        check("a_T1", Ta, 32'd1);
        tick(); tick();
        arr = '0;
        check("a_q3",   qa, 32'd3);
        check("a_dep0", dep, 32'h0);

        // Drain lane a under GREEN: departures on edges 2,4,6
        La = C_GREEN;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("drain_q%0d", i), qa, exp_qa[i]);
            check($sformatf("drain_dep%0d", i), dep[0], exp_dep[i]);
        end
        check("drain_Ta", Ta, 32'd0);
        tick();
        check("drain_idle", dep, 32'h0);

        // Lane al: GREEN does not permit the left lane, LEFT does
        La = C_RED; arr = 4'b0010;
        tick();
        arr = '0;
        check("al_q1", qal, 32'd1);
        La = C_GREEN;
        for (int i = 0; i < 10; i++) tick();
        check("al_green_q",   qal, 32'd1);
        check("al_green_dep", dep, 32'h0);
        La = C_LEFT;
        tick();
        check("al_left1_q", qal, 32'd1);
        check("al_left1_d", dep, 32'h0);
        tick();
        check("al_left2_q", qal, 32'd0);
        check("al_left2_d", dep, 32'b0010);
        check("al_Tal",     Tal, 32'd0);
        La = C_RED;

        // Lane b: arrival on the departure edge keeps qb and still pulses dep
        arr = 4'b0100;
        tick(); tick();
        arr = '0;
        check("b_q2", qb, 32'd2);
        Lb = C_GREEN;
        tick();
        check("b_half", dep, 32'h0);
        arr = 4'b0100;
        tick();
        arr = '0; Lb = C_RED;
        check("b_both_q", qb, 32'd2);
        check("b_both_d", dep, 32'b0100);
        tick();
        check("b_after_q", qb, 32'd2);
        check("b_after_d", dep, 32'h0);

        // Lane bl saturation under RED
        arr = 4'b1000;
        for (int i = 0; i < 15; i++) tick();
        check("bl_q15",  qbl, 32'd15);
        check("bl_nov",  ovf, 32'h0);
        tick();
        arr = '0;
        check("bl_sat_q", qbl, 32'd15);
        check("bl_ovf",   ovf, 32'b1000);
        tick();
        check("bl_sticky", ovf, 32'b1000);

        // LEFT on B drains bl only; qb untouched
        Lb = C_LEFT;
        tick(); tick();
        check("bl_dep_q",  qbl, 32'd14);
        check("bl_dep_d",  dep, 32'b1000);
        check("bl_ovf_kp", ovf, 32'b1000);
        check("bl_qb",     qb, 32'd2);

        // Reset mid-operation clears everything
        Lb = C_GREEN;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_q",   {qa, qal, qb, qbl}, 32'h0);
        check("mrst_T",   {Ta, Tal, Tb, Tbl}, 32'h0);
        check("mrst_dep", dep, 32'h0);
        check("mrst_ovf", ovf, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
